// File: rtl/led_pkg.sv
// Shared definitions for the LED display group: scan state encoding and a
// width helper that never returns zero.
package led_pkg;

  typedef enum logic {
    S_GAP  = 1'b0,
    S_SHOW = 1'b1
  } state_t;

  // Bit width needed to hold 0..n-1, never below 1 so single-value counters
  // still get a real register.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_scan_lz_blank.sv
// Leading-zero detector for the digit about to be shown: a digit above 0 is
// blanked when it and every more-significant nibble are zero.
module lz_blank
  import led_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int IW     = clog2_min1(DIGITS)
) (
  input  logic [4*DIGITS-1:0] shadow,
  input  logic [IW-1:0]       idx,
  input  logic                blank_lz,
  output logic                blank
);

  logic nz;

  // Look for any non-zero nibble at or above idx.
  always_comb begin
    nz = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= int'(idx) && shadow[4*i +: 4] != 4'h0) nz = 1'b1;
    end
    blank = blank_lz && (idx != '0) && !nz;
  end

endmodule

// File: rtl/led_scan.sv
// Time-multiplexed 7-segment scanner. Each digit gets GAP all-off cycles
// followed by DIV lit cycles. New display words are staged in a pending
// register and only reach the shadow register at frame boundaries.
module led_scan
  import led_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int GAP    = 16
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] value,
  input  logic                blank_lz,
  output logic [3:0]          nib,
  output logic                n_en,
  output logic [DIGITS-1:0]   dig_sel,
  output logic                frame
);

  localparam int CMAX = (DIV > GAP) ? DIV : GAP;
  localparam int CW   = clog2_min1(CMAX);
  localparam int IW   = clog2_min1(DIGITS);

  localparam logic [CW-1:0] DIV_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  state_t              state, state_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [IW-1:0]       idx, idx_nx;
  logic                commit;
  logic [4*DIGITS-1:0] shadow, pending;
  logic                pend_v;

  logic [DIGITS-1:0]   sel_nx;
  logic [3:0]          nib_nx;
  logic                n_en_nx;
  logic                blank;

  // Next-state logic: one counter serves both states; idx advances as each
  // digit's SHOW period ends, and the last digit's end is the commit point.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    idx_nx   = idx;
    commit   = 1'b0;
    case (state)
      S_GAP: begin
        if (cnt == GAP_END) begin
          state_nx = S_SHOW;
          cnt_nx   = '0;
        end
      end
      default: begin
        if (cnt == DIV_END) begin
          state_nx = S_GAP;
          cnt_nx   = '0;
          if (idx == IDX_LAST) begin
            idx_nx = '0;
            commit = 1'b1;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
    endcase
  end

  // Blanking is evaluated for the digit entering the next cycle so that the
  // registered n_en lines up with the registered strobe.
  lz_blank #(.DIGITS(DIGITS), .IW(IW)) u_lz (
    .shadow   (shadow),
    .idx      (idx_nx),
    .blank_lz (blank_lz),
    .blank    (blank)
  );

  // Output values for the next cycle; nib is left untouched during GAP.
  always_comb begin
    sel_nx  = '1;
    nib_nx  = nib;
    n_en_nx = 1'b1;
    if (state_nx == S_SHOW) begin
      sel_nx[idx_nx] = 1'b0;
      nib_nx         = shadow[{idx_nx, 2'b00} +: 4];
      n_en_nx        = blank;
    end
  end

  // Scan state, counter and digit index.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= S_GAP;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  // Display word staging: a load landing on the commit cycle bypasses pending.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pending <= '0;
      pend_v  <= 1'b0;
      shadow  <= '0;
    end else begin
      if (load) pending <= value;
      if (commit) begin
        pend_v <= 1'b0;
        if (load)        shadow <= value;
        else if (pend_v) shadow <= pending;
      end else if (load) begin
        pend_v <= 1'b1;
      end
    end
  end

  // Registered outputs so nothing combinational reaches the pins.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      nib     <= 4'h0;
      n_en    <= 1'b1;
      dig_sel <= '1;
      frame   <= 1'b0;
    end else begin
      nib     <= nib_nx;
      n_en    <= n_en_nx;
      dig_sel <= sel_nx;
      frame   <= commit;
    end
  end

endmodule

// File: tb/tb_led_scan.sv
// Bench for led_scan with DIGITS=4, DIV=4, GAP=1 (20-cycle frames).
// A cycle-indexed reference model predicts every output each cycle; a table
// of display words with hand-derived per-digit expectations and a few
// hand-written sequences cover blanking, load timing and mid-scan reset.
module tb_led_scan;

  localparam int DIGITS = 4;
  localparam int FR     = 20;

  logic        clk;
  logic        n_rst;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic [3:0]  nib;
  logic        n_en;
  logic [3:0]  dig_sel;
  logic        frame;

  led_scan #(.DIGITS(DIGITS), .DIV(4), .GAP(1)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (load),
    .value    (value),
    .blank_lz (blank_lz),
    .nib      (nib),
    .n_en     (n_en),
    .dig_sel  (dig_sel),
    .frame    (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: t counts cycles since reset release.
  int          t;
  logic [15:0] disp, pend;
  bit          pv;
  logic [3:0]  last_nib;
  bit          blz_prev;

  typedef struct packed {
    logic [15:0] value;
    logic        blz;
    logic [15:0] e_nib;
    logic [3:0]  e_nen;
  } vec_t;

  vec_t       tbl[6];
  logic [3:0] sel_tbl[4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", name, t, got, exp);
    end
  endtask

  task automatic model_reset();
    t        = 0;
    disp     = 16'h0;
    pend     = 16'h0;
    pv       = 0;
    last_nib = 4'h0;
    blz_prev = 0;
  endtask

  // Expected outputs from the cycle's position inside the 20-cycle frame.
  task automatic model_check();
    int pos, d, w;
    logic [3:0] e_sel, e_nib;
    logic       e_nen;
    pos = t % FR;
    d   = pos / 5;
    w   = pos % 5;
    if (w == 0) begin
      e_sel = 4'hF;
      e_nib = last_nib;
      e_nen = 1'b1;
    end else begin
      e_sel = ~(4'b0001 << d);
      e_nib = 4'(disp >> (4 * d));
      e_nen = blz_prev && (d > 0) && ((disp >> (4 * d)) == 16'h0);
    end
    chk("m_dig_sel", 32'(dig_sel), 32'(e_sel));
    chk("m_nib",     32'(nib),     32'(e_nib));
    chk("m_n_en",    32'(n_en),    32'(e_nen));
    chk("m_frame",   32'(frame),   32'((pos == 0) && (t >= FR)));
    last_nib = e_nib;
  endtask

  // One cycle: check, drive inputs, advance the model, move to next mid-cycle.
  task automatic step(input bit ld, input logic [15:0] val, input bit blz);
    model_check();
    load     = ld;
    value    = val;
    blank_lz = blz;
    if (ld) begin
      pend = val;
      pv   = 1;
    end
    if ((t % FR) == FR - 1 && pv) begin
      disp = pend;
      pv   = 0;
    end
    blz_prev = blz;
    @(posedge clk);
    @(negedge clk);
    t++;
  endtask

  task automatic check_tbl(input vec_t v, input int c);
    int d, w;
    d = c / 5;
    w = c % 5;
    if (w == 0) begin
      chk("t_gap_sel",  32'(dig_sel), 32'h0000_000F);
      chk("t_gap_n_en", 32'(n_en),    32'h1);
    end else begin
      chk("t_sel",  32'(dig_sel), 32'(sel_tbl[d]));
      chk("t_nib",  32'(nib),     32'(v.e_nib[4*d +: 4]));
      chk("t_n_en", 32'(n_en),    32'(v.e_nen[d]));
    end
    chk("t_frame", 32'(frame), 32'(c == 0));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout t=%0d", t);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{value: 16'h1234, blz: 1'b0, e_nib: 16'h1234, e_nen: 4'b0000};
    tbl[1] = '{value: 16'h0050, blz: 1'b1, e_nib: 16'h0050, e_nen: 4'b1100};
    tbl[2] = '{value: 16'h0000, blz: 1'b1, e_nib: 16'h0000, e_nen: 4'b1110};
    tbl[3] = '{value: 16'hABCD, blz: 1'b0, e_nib: 16'hABCD, e_nen: 4'b0000};
    tbl[4] = '{value: 16'h0700, blz: 1'b1, e_nib: 16'h0700, e_nen: 4'b1000};
    tbl[5] = '{value: 16'h0050, blz: 1'b0, e_nib: 16'h0050, e_nen: 4'b0000};
    sel_tbl[0] = 4'b1110;
    sel_tbl[1] = 4'b1101;
    sel_tbl[2] = 4'b1011;
    sel_tbl[3] = 4'b0111;

    n_rst    = 1'b0;
    load     = 1'b0;
    value    = 16'h0;
    blank_lz = 1'b0;
    model_reset();

    // Reset values while held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dig_sel", 32'(dig_sel), 32'h0000_000F);
    chk("rst_n_en",    32'(n_en),    32'h1);
    chk("rst_nib",     32'(nib),     32'h0);
    chk("rst_frame",   32'(frame),   32'h0);
    n_rst = 1'b1;

    // First frame shows zeros; stage the first table word mid-frame.
    for (int c = 0; c < FR; c++) begin
      if (c == 1) begin
        chk("f1_sel_d0", 32'(dig_sel), 32'h0000_000E);
        chk("f1_nib_d0", 32'(nib),     32'h0);
        chk("f1_nen_d0", 32'(n_en),    32'h0);
      end
      step(c == 3, tbl[0].value, 1'b0);
    end

    // Table frames: each frame shows tbl[k] while tbl[k+1] is loaded at idx1.
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < FR; c++) begin
        check_tbl(tbl[k], c);
        step((c == 7) && (k < 5), tbl[(k + 1) % 6].value, tbl[k].blz);
      end
    end

    // Load on the commit cycle goes straight to the display.
    for (int c = 0; c < FR; c++) step(c == FR - 1, 16'h5678, 1'b0);
    for (int c = 0; c < FR; c++) begin
      if (c == 0)  chk("commit_pend_v", 32'(dut.pend_v), 32'h0);
      if (c == 1)  chk("commit_ld_d0",  32'(nib), 32'h8);
      if (c == 16) chk("commit_ld_d3",  32'(nib), 32'h5);
      step((c == 3) || (c == 11), (c == 3) ? 16'h1111 : 16'h2222, 1'b0);
    end
    // Two loads in one frame: only the second reaches the display.
    for (int c = 0; c < FR; c++) begin
      if (c == 1)  chk("two_ld_d0", 32'(nib), 32'h2);
      if (c == 16) chk("two_ld_d3", 32'(nib), 32'h2);
      step(1'b0, 16'h0, 1'b0);
    end

    // Randomized traffic with mixed leading-zero patterns.
    for (int i = 0; i < 10 * FR; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      v = v >> (4 * $urandom_range(0, 4));
      step($urandom_range(0, 9) == 0, v, 1'($urandom_range(0, 1)));
    end
    while ((t % FR) != 12) step(1'b0, 16'h0, 1'b0);

    // Asynchronous reset in the middle of digit 2's SHOW period.
    chk("pre_rst_sel", 32'(dig_sel), 32'h0000_000B);
    n_rst = 1'b0;
    #1;
    chk("arst_dig_sel", 32'(dig_sel), 32'h0000_000F);
    chk("arst_n_en",    32'(n_en),    32'h1);
    chk("arst_nib",     32'(nib),     32'h0);
    chk("arst_frame",   32'(frame),   32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    model_reset();
    for (int c = 0; c < 2 * FR; c++) begin
      if (c == 1) chk("post_rst_sel_d0", 32'(dig_sel), 32'h0000_000E);
      step(1'b0, 16'h0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
